if_id_stage: RTL

Pipeline register between instruction fetch and decode. It latches each fetched instruction word with its PC+4 and detects load-use hazards against the load currently in EX. On a hazard it holds fetch for one cycle, keeps the overtaken fetch word in a one-entry skid buffer and flushes on any taken redirect. It also drives the bubble request into ID/EX and the PC-hold request back to fetch.

---
 rtl/if_id_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, one-entry skid buffer and redirect flush.
// Optional IF_ID_STATS_EN adds saturating stall/flush counters.
module if_id_stage #(
  parameter int ISA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ISA_WIDTH-1:0]      if_instruction,
  input  logic [ISA_WIDTH-1:0]      if_pc_plus4,
  input  logic                      if_valid,
  input  logic                      redirect,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic [ISA_WIDTH-1:0]      id_instruction,
  output logic [ISA_WIDTH-1:0]      id_pc_plus4,
  output logic                      id_valid,
  output logic                      fetch_hold,
  output logic                      id_ex_bubble
`ifdef IF_ID_STATS_EN
  ,
  output logic [31:0]               stall_count,
  output logic [31:0]               flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ISA_WIDTH-1:0]  r_id_instr, w_id_instr_next;
  logic [ISA_WIDTH-1:0]  r_id_pc, w_id_pc_next;
  logic                  r_id_valid, w_id_valid_next;
  logic [ISA_WIDTH-1:0]  r_skid_instr, w_skid_instr_next;
  logic [ISA_WIDTH-1:0]  r_skid_pc, w_skid_pc_next;
  logic                  r_skid_valid, w_skid_valid_next;

  logic [5:0]                w_opcode;
  logic [REG_ADDR_WIDTH-1:0] w_rs;
  logic [REG_ADDR_WIDTH-1:0] w_rt;
  logic                      w_uses_rt;
  logic                      w_load_use;
  logic                      w_hold;

  // Hazard detection looks only at the ID register, never at the incoming fetch word.
  assign w_opcode   = r_id_instr[31:26];
  assign w_rs       = r_id_instr[21 +: REG_ADDR_WIDTH];
  assign w_rt       = r_id_instr[16 +: REG_ADDR_WIDTH];
  assign w_uses_rt  = (w_opcode == 6'b000000) || (w_opcode == 6'b000100) ||
                      (w_opcode == 6'b000101) || (w_opcode == 6'b101011);
  assign w_load_use = r_id_valid && ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == w_rs) || (w_uses_rt && (ex_rt == w_rt)));
  assign w_hold     = w_load_use && !redirect && !reset;

  assign fetch_hold     = w_hold;
  assign id_ex_bubble   = w_hold;
  assign id_instruction = r_id_instr;
  assign id_pc_plus4    = r_id_pc;
  assign id_valid       = r_id_valid;

  always_comb begin
    w_state_next      = r_state;
    w_id_instr_next   = r_id_instr;
    w_id_pc_next      = r_id_pc;
    w_id_valid_next   = r_id_valid;
    w_skid_instr_next = r_skid_instr;
    w_skid_pc_next    = r_skid_pc;
    w_skid_valid_next = r_skid_valid;

    if (redirect) begin
      w_id_valid_next   = 1'b0;
      w_id_instr_next   = '0;
      w_skid_valid_next = 1'b0;
      w_state_next      = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          w_id_instr_next = if_instruction;
          w_id_pc_next    = if_pc_plus4;
          w_id_valid_next = if_valid;
          w_state_next    = if_valid ? ST_FULL : ST_EMPTY;
        end
        ST_FULL: begin
          if (w_load_use) begin
            // The word fetched during the stall would otherwise be lost.
            if (if_valid) begin
              w_skid_instr_next = if_instruction;
              w_skid_pc_next    = if_pc_plus4;
              w_skid_valid_next = 1'b1;
              w_state_next      = ST_HOLD;
            end
          end else begin
            w_id_instr_next = if_instruction;
            w_id_pc_next    = if_pc_plus4;
            w_id_valid_next = if_valid;
            w_state_next    = if_valid ? ST_FULL : ST_EMPTY;
          end
        end
        ST_HOLD: begin
          if (!w_load_use) begin
            w_id_instr_next   = r_skid_instr;
            w_id_pc_next      = r_skid_pc;
            w_id_valid_next   = 1'b1;
            w_skid_valid_next = 1'b0;
            w_state_next      = ST_FULL;
          end
        end
        default: begin
          w_id_valid_next   = 1'b0;
          w_skid_valid_next = 1'b0;
          w_state_next      = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_id_instr   <= '0;
      r_id_pc      <= '0;
      r_id_valid   <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_id_instr   <= w_id_instr_next;
      r_id_pc      <= w_id_pc_next;
      r_id_valid   <= w_id_valid_next;
      r_skid_instr <= w_skid_instr_next;
      r_skid_pc    <= w_skid_pc_next;
      r_skid_valid <= w_skid_valid_next;
    end
  end

`ifdef IF_ID_STATS_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  // Flushes are counted only when live work is actually discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_hold && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
      if (redirect && (r_id_valid || r_skid_valid) && (r_flush_count != 32'hFFFF_FFFF))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

endmodule
